// File: rtl/usr_seq.sv
// Command sequencer driving a universal shift register: hold / load / shift-by-count commands.
// Latency: first register action in the cycle after acceptance; done pulses one cycle after the last action.
// Backpressure: cmd_ready low while a load or shift is in progress; a new command may be taken in the done cycle.
//
// Ports:
//   clk, clr           clock (rising edge), synchronous active-low reset
//   cmd_valid/ready    command handshake; cmd_op, cmd_cnt, cmd_data, cmd_fill form the command
//   select, par_in     downstream register mode and parallel load value
//   rin, lin           downstream serial inputs (rin on shift-left, lin on shift-right)
//   busy, done         command in progress / one-cycle completion pulse
module usr_seq #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] par_in,
    output logic             rin,
    output logic             lin,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_SHL  = 2'd1;
    localparam logic [1:0] OP_LOAD = 2'd3;

    state_t           state, state_nxt;
    logic [1:0]       op_q, op_nxt, src_op;
    logic             fill_q, fill_nxt, src_fill;
    logic [WIDTH-1:0] shadow_q, shadow_nxt, src_data;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             accept;
    logic             shift_bit;

    logic [1:0]       select_nxt;
    logic [WIDTH-1:0] par_in_nxt;
    logic             rin_nxt, lin_nxt, busy_nxt, done_nxt, ready_nxt;

    // cmd_ready is only high in IDLE/DONE (and never in the cycle right after reset).
    assign accept = cmd_valid && cmd_ready;

    // On acceptance the fresh command feeds the output computation directly, so the
    // first action lands in the very next cycle; otherwise the captured copy is used.
    assign src_op   = accept ? cmd_op   : op_q;
    assign src_fill = accept ? cmd_fill : fill_q;
    assign src_data = accept ? cmd_data : shadow_q;

    function automatic state_t decode(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        if (op == OP_LOAD)
            return ST_LOAD;
        else if (op != OP_HOLD && cnt != '0)
            return ST_SHIFT;
        else
            return ST_DONE;
    endfunction

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = accept ? decode(cmd_op, cmd_cnt) : ST_IDLE;
            ST_LOAD:  state_nxt = ST_DONE;
            // cnt_q holds the number of shift cycles left including the current one.
            ST_SHIFT: state_nxt = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_nxt = accept ? decode(cmd_op, cmd_cnt) : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered: compute what the next state must present.
    always_comb begin
        select_nxt = 2'd0;
        par_in_nxt = par_in;
        rin_nxt    = 1'b0;
        lin_nxt    = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        ready_nxt  = 1'b0;
        op_nxt     = src_op;
        fill_nxt   = src_fill;
        shadow_nxt = src_data;
        cnt_nxt    = accept ? cmd_cnt : cnt_q;
        shift_bit  = src_data[0];
        case (state_nxt)
            ST_IDLE: ready_nxt = 1'b1;
            ST_LOAD: begin
                select_nxt = 2'd3;
                par_in_nxt = src_data;
                busy_nxt   = 1'b1;
            end
            ST_SHIFT: begin
                select_nxt = (src_op == OP_SHL) ? 2'd1 : 2'd2;
                busy_nxt   = 1'b1;
                if (src_op == OP_SHL)
                    rin_nxt = shift_bit;
                else
                    lin_nxt = shift_bit;
                // Shadow always exposes the next serial bit at bit 0; once the
                // data bits run out the fill bit has propagated down.
                shadow_nxt            = src_data >> 1;
                shadow_nxt[WIDTH-1]   = src_fill;
                if (!accept)
                    cnt_nxt = cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                ready_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            fill_q    <= 1'b0;
            shadow_q  <= '0;
            cnt_q     <= '0;
            select    <= 2'd0;
            par_in    <= '0;
            rin       <= 1'b0;
            lin       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            fill_q    <= fill_nxt;
            shadow_q  <= shadow_nxt;
            cnt_q     <= cnt_nxt;
            select    <= select_nxt;
            par_in    <= par_in_nxt;
            rin       <= rin_nxt;
            lin       <= lin_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cmd_ready <= ready_nxt;
        end
    end

endmodule

// File: doc/usr_seq.md
# usr_seq

Command sequencer that sits directly upstream of the team's 3-bit universal shift register and drives its `select`, `par_in`, `lin` and `rin` inputs. It accepts one command per valid/ready handshake: hold, load, or shift left/right by a count. It then drives the register cycle by cycle, with a per-cycle serial bit sequence, and pulses `done` when the command has been fully applied. All outputs are registered, so the downstream register acts on exactly the cycles listed below.

## Interface
- `WIDTH`, default 3: width of the downstream register, `par_in` and `cmd_data`.
- `CNT_W`, default 3: width of the shift count. Maximum shift per command is 2^CNT_W−1.
- `clk`, input, 1: single clock, rising edge.
- `clr`, input, 1: reset. Synchronous and active-low.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: sequencer can accept a command.
- `cmd_op`, input, 2: 0 = hold, 1 = shift left, 2 = shift right, 3 = parallel load.
- `cmd_cnt`, input, CNT_W: number of shift cycles. Ignored for ops 0 and 3.
- `cmd_data`, input, WIDTH: load value for op 3, or serial source bits for ops 1 and 2.
- `cmd_fill`, input, 1: serial bit used once `cmd_data` bits are exhausted.
- `select`, output, 2: to the register's `select`.
- `par_in`, output, WIDTH: to the register's `par_in`.
- `rin`, output, 1: to the register's `rin` (serial in on shift-left).
- `lin`, output, 1: to the register's `lin` (serial in on shift-right).
- `busy`, output, 1: a command is being applied.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `cmd_ready`=1 and `select`=0.
  - On `cmd_valid`&&`cmd_ready`, capture op, count, data and fill into internal registers.
  - Next state: op 3 → LOAD; op 1/2 with count≠0 → SHIFT; op 0, or op 1/2 with count=0 → DONE.
- **LOAD** (one cycle): `select`=3, `par_in`=captured data, `busy`=1. Then go to DONE.
- **SHIFT** (exactly count cycles):
  - `select`=1 for op 1, `select`=2 for op 2. `busy`=1.
  - Shift bit for shift cycle i (0-based) is data[i] for i<WIDTH, otherwise fill.
  - Op 1 drives the bit on `rin` with `lin`=0. Op 2 drives it on `lin` with `rin`=0.
  - An internal down-counter is loaded with count. SHIFT exits to DONE in the cycle the counter reaches 1.
  - The data shadow shifts right each cycle and fills from the top with the fill bit.
- **DONE** (one cycle):
  - `done`=1, `select`=0, `busy`=0, `cmd_ready`=1.
  - A command may be accepted in this cycle; the state transitions as from IDLE.
  - Otherwise go to IDLE.
- `par_in`: holds its last driven value outside LOAD. `lin`/`rin`: 0 outside SHIFT.
- `cmd_ready`: 0 in LOAD and SHIFT. Inputs are ignored there, and `cmd_valid` may stay high without effect.
- Counter arithmetic is CNT_W bits and never wraps, because count=0 bypasses SHIFT.
- Reset (`clr`=0 at a rising edge), from any state including mid-LOAD/SHIFT:
  - Next state is IDLE; `done` is not pulsed.
  - Outputs become `select`=0, `par_in`=0, `lin`=0, `rin`=0, `busy`=0, `done`=0, `cmd_ready`=0.
  - `cmd_ready` rises in the first cycle after an edge sampling `clr`=1.

## Timing
- Accept at edge k. The first active `select` is driven in cycle k+1, and the register acts at edge k+1.
- Load: LOAD in cycle k+1, DONE in k+2. Acceptance to done = 2 cycles.
- Shift N: SHIFT in cycles k+1..k+N, DONE in k+N+1.
- Hold, or count 0: DONE in k+1.
- Back-to-back: a command accepted in a DONE cycle is issued with no intervening idle cycle. Steady throughput for load commands is one load per 2 cycles.
- `done` is never high for two consecutive cycles unless consecutive zero-length commands are accepted.

## Test plan
- Reset then load: hold `clr`=0 for 2 cycles, check all outputs 0 and `cmd_ready`=0. Release `clr`; in the next cycle `cmd_ready`=1. Issue op 3 with data 3'b101 → LOAD cycle shows `select`=3 and `par_in`=101; `done` next cycle; downstream q=101.
- Shift left, count 2, data 3'b010, fill 1, starting from q=101 → `rin` sequence 0,1 with `select`=1 for 2 cycles; q goes 010 then 101; `done` at k+3.
- Shift right, count 5, data 3'b110, fill 0 → `lin` sequence 0,1,1,0,0 (fill used after 3 bits), `select`=2 for 5 cycles, `busy`=1 throughout, `done` at k+6.
- Zero-length commands: op 0, then op 1 with count 0, offered back-to-back → each yields `done` one cycle after acceptance; `select` stays 0; `cmd_ready` stays 1.
- Back-to-back: new load offered while `cmd_valid` is held high during a 3-cycle shift → it is not accepted until the DONE cycle; the LOAD cycle immediately follows DONE.
- Reset mid-shift: `clr`=0 at the 2nd of 4 shift cycles → next cycle `select`=0, `busy`=0, no `done` pulse, `cmd_ready`=0; normal operation resumes after release.
